bitpack_engine: RTL



---
 rtl/bitpack_pkg.sv | 35 +++
 rtl/bitpack_engine_if.sv | 39 +++
 rtl/bitpack_packer.sv | 112 +++++++++++
 rtl/bitpack_engine.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bitpack_pkg.sv
// bitpack_pkg: shared types, defaults and helpers for the bitpack engine.
//   state_t         : top-level sequencing states (IDLE, RUN, DRAIN)
//   DEFAULT_*       : default PACK_BITS / CHUNK_WORDS
//   values_per_word : number of packed values in one 32-bit output word
//   chunk_count     : request length, min(remaining, chunk)
//   packed_words    : output word count for a given input word count
package bitpack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DEFAULT_PACK_BITS   = 8;
  localparam int DEFAULT_CHUNK_WORDS = 256;

  function automatic int values_per_word(input int pack_bits);
    return 32 / pack_bits;
  endfunction

  function automatic logic [15:0] chunk_count(input logic [31:0] remaining,
                                              input logic [31:0] chunk);
    return (remaining < chunk) ? remaining[15:0] : chunk[15:0];
  endfunction

  // SIZE * PACK_BITS can exceed 32 bits, so the rounding is done in 38 bits.
  function automatic logic [31:0] packed_words(input logic [31:0] size,
                                               input int pack_bits);
    logic [37:0] t;
    t = ({6'b0, size} * 38'(pack_bits) + 38'd31) >> 5;
    return t[31:0];
  endfunction

endpackage

// File: rtl/bitpack_engine_if.sv
// bitpack_engine_if: data-mover side of the bitpack engine.
//   read  channel: read_addr/read_count/read_req request, read_busy status,
//                  read_data/read_valid/read_ready input stream
//   write channel: write_addr/write_count/write_req request, write_busy status,
//                  write_data/write_valid/write_ready output stream
//   master modport: the engine; slave modport: the data mover.
interface bitpack_engine_if;

  logic [31:0] read_addr;
  logic [15:0] read_count;
  logic        read_req;
  logic        read_busy;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_ready;

  logic [31:0] write_addr;
  logic [15:0] write_count;
  logic        write_req;
  logic        write_busy;
  logic [31:0] write_data;
  logic        write_valid;
  logic        write_ready;

  modport master (
    output read_addr, read_count, read_req, read_ready,
    input  read_busy, read_data, read_valid,
    output write_addr, write_count, write_req, write_data, write_valid,
    input  write_busy, write_ready
  );

  modport slave (
    input  read_addr, read_count, read_req, read_ready,
    output read_busy, read_data, read_valid,
    input  write_addr, write_count, write_req, write_data, write_valid,
    output write_busy, write_ready
  );

endinterface

// File: rtl/bitpack_packer.sv
// bitpack_packer: packs PACK_BITS-wide values into 32-bit words.
//   clk, rst          : clock, synchronous active-high reset
//   in_value/in_valid/in_ready/in_last : input stream; in_last flushes a
//                       partial word
//   out_data/out_valid/out_ready       : packed output stream
// Build option BITPACK_MSB_FIRST_EN: first value lands in the top bits and a
// partial word is zero-padded at the bottom; otherwise LSB-first, zero-padded
// at the top.
module bitpack_packer
  import bitpack_pkg::*;
#(
  parameter int PACK_BITS = DEFAULT_PACK_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PACK_BITS-1:0] in_value,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int VPW = values_per_word(PACK_BITS);
  localparam int SW  = $clog2(VPW);
  localparam logic [SW-1:0] LAST_SLOT = SW'(VPW - 1);

  logic [31:0]   acc_q, acc_d, out_q, out_d, base, merged;
  logic [SW-1:0] slot_q, slot_d;
  logic          acc_full_q, acc_full_d, out_valid_q, out_valid_d;
  logic          out_free, take, complete;

  function automatic logic [31:0] place(input logic [PACK_BITS-1:0] v,
                                        input logic [SW-1:0] s);
    logic [31:0] w;
    w = {{(32-PACK_BITS){1'b0}}, v};
`ifdef BITPACK_MSB_FIRST_EN
    return w << (32 - PACK_BITS * (int'(s) + 1));
`else
    return w << (PACK_BITS * int'(s));
`endif
  endfunction

  // The output register can take a word this cycle if empty or being drained.
  assign out_free  = !out_valid_q || out_ready;
  // acc_full means a complete word is parked waiting for the output register.
  assign in_ready  = out_free || !acc_full_q;
  assign take      = in_valid && in_ready;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

  always_comb begin
    // NOTE: every next-state value gets a default first; a path that left one
    // unassigned would infer a latch.
    acc_d       = acc_q;
    slot_d      = slot_q;
    acc_full_d  = acc_full_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    base        = acc_q;

    // Parked word moves out first; a new value then starts a fresh word.
    if (acc_full_q && out_free) begin
      out_d       = acc_q;
      out_valid_d = 1'b1;
      acc_d       = '0;
      slot_d      = '0;
      acc_full_d  = 1'b0;
      base        = '0;
    end

    merged   = base | place(in_value, slot_d);
    complete = take && ((slot_d == LAST_SLOT) || in_last);

    if (take) begin
      if (complete) begin
        slot_d = '0;
        if (!out_valid_d) begin
          out_d       = merged;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d      = merged;
          acc_full_d = 1'b1;
        end
      end else begin
        acc_d  = merged;
        slot_d = slot_d + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      acc_q       <= '0;
      slot_q      <= '0;
      acc_full_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      slot_q      <= slot_d;
      acc_full_q  <= acc_full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/bitpack_engine.sv
// bitpack_engine: reads SIZE words from SRC, keeps the low PACK_BITS bits of
// each, packs 32/PACK_BITS values per word and writes them to DST.
//   clk, rst        : clock, synchronous active-high reset
//   go, done        : start pulse, idle/complete flag (1 out of reset)
//   src, dst, size  : byte addresses and input word count, latched on go
//   dm              : data-mover read/write request and stream channels
// Build option BITPACK_MSB_FIRST_EN selects MSB-first packing (see packer).
module bitpack_engine
  import bitpack_pkg::*;
#(
  parameter int PACK_BITS   = DEFAULT_PACK_BITS,
  parameter int CHUNK_WORDS = DEFAULT_CHUNK_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  output logic                    done,
  input  logic [31:0]             src,
  input  logic [31:0]             dst,
  input  logic [31:0]             size,
  bitpack_engine_if.master        dm
);

  localparam logic [31:0] CHUNK = 32'(CHUNK_WORDS);

  state_t      state;
  logic [31:0] src_q, dst_q, size_q, out_words;
  logic [31:0] rd_req_words, wr_req_words, rd_taken, wr_sent;
  logic [15:0] wr_beats_left;

  logic [31:0] go_out_words;
  logic [15:0] go_rd_count, go_wr_count, rd_count, wr_count;
  logic        inputs_left, in_last, rd_fire, wr_fire, wr_open;
  logic        pk_in_ready, pk_out_valid;
  logic [31:0] pk_out_data;

  assign go_out_words = packed_words(size, PACK_BITS);
  assign go_rd_count  = chunk_count(size, CHUNK);
  assign go_wr_count  = chunk_count(go_out_words, CHUNK);
  assign rd_count     = chunk_count(size_q - rd_req_words, CHUNK);
  assign wr_count     = chunk_count(out_words - wr_req_words, CHUNK);

  assign inputs_left   = (state == RUN) && (rd_taken != size_q);
  assign in_last       = (rd_taken == size_q - 32'd1);
  assign dm.read_ready = inputs_left && pk_in_ready;
  assign rd_fire       = dm.read_valid && dm.read_ready;

  // Beats are offered only inside an active write request.
  assign wr_open        = dm.write_busy && (wr_beats_left != 16'd0);
  assign dm.write_valid = pk_out_valid && wr_open;
  assign dm.write_data  = pk_out_data;
  assign wr_fire        = dm.write_valid && dm.write_ready;

  bitpack_packer #(
    .PACK_BITS(PACK_BITS)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .in_value (dm.read_data[PACK_BITS-1:0]),
    .in_valid (dm.read_valid && inputs_left),
    .in_last  (in_last),
    .in_ready (pk_in_ready),
    .out_data (pk_out_data),
    .out_valid(pk_out_valid),
    .out_ready(wr_open && dm.write_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      done           <= 1'b1;
      src_q          <= '0;
      dst_q          <= '0;
      size_q         <= '0;
      out_words      <= '0;
      rd_req_words   <= '0;
      wr_req_words   <= '0;
      rd_taken       <= '0;
      wr_sent        <= '0;
      wr_beats_left  <= '0;
      dm.read_req    <= 1'b0;
      dm.read_addr   <= '0;
      dm.read_count  <= '0;
      dm.write_req   <= 1'b0;
      dm.write_addr  <= '0;
      dm.write_count <= '0;
    end else begin
      dm.read_req  <= 1'b0;
      dm.write_req <= 1'b0;
      case (state)
        IDLE: begin
          if (go && (size != 32'd0)) begin
            state         <= RUN;
            done          <= 1'b0;
            src_q         <= src;
            dst_q         <= dst;
            size_q        <= size;
            out_words     <= go_out_words;
            rd_taken      <= '0;
            wr_sent       <= '0;
            // First requests go out straight from the GO inputs so the read
            // request appears the cycle after GO.
            dm.read_req    <= 1'b1;
            dm.read_addr   <= src;
            dm.read_count  <= go_rd_count;
            rd_req_words   <= {16'b0, go_rd_count};
            dm.write_req   <= 1'b1;
            dm.write_addr  <= dst;
            dm.write_count <= go_wr_count;
            wr_req_words   <= {16'b0, go_wr_count};
            wr_beats_left  <= go_wr_count;
          end
        end
        RUN: begin
          // Checking the previous REQ keeps each request a single-cycle pulse
          // while the mover has not yet raised BUSY.
          if ((rd_req_words != size_q) && !dm.read_busy && !dm.read_req) begin
            dm.read_req   <= 1'b1;
            dm.read_addr  <= src_q + {rd_req_words[29:0], 2'b00};
            dm.read_count <= rd_count;
            rd_req_words  <= rd_req_words + {16'b0, rd_count};
          end
          if ((wr_req_words != out_words) && !dm.write_busy && !dm.write_req) begin
            dm.write_req   <= 1'b1;
            dm.write_addr  <= dst_q + {wr_req_words[29:0], 2'b00};
            dm.write_count <= wr_count;
            wr_req_words   <= wr_req_words + {16'b0, wr_count};
            wr_beats_left  <= wr_count;
          end
          if (rd_fire) rd_taken <= rd_taken + 32'd1;
          // A new write request needs BUSY low, a beat needs it high, so
          // these two updates of wr_beats_left never coincide.
          if (wr_fire) begin
            wr_sent       <= wr_sent + 32'd1;
            wr_beats_left <= wr_beats_left - 16'd1;
            if (wr_sent == out_words - 32'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!dm.write_busy) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
